// File: rtl/bus_sel_pipe_pkg.sv
// Shared bus-select definitions: the empty-select code, the default slave count
// and a helper that gives the narrowest legal encoded-select width.
package bus_sel_pipe_pkg;

    localparam int SEL_NONE          = 0;
    localparam int DEFAULT_NUM_SLAVE = 5;
    localparam int MAX_NUM_SLAVE     = 15;

    // One extra code point is reserved for SEL_NONE.
    function automatic int min_sel_w(input int num_slave);
        return $clog2(num_slave + 1);
    endfunction

    typedef enum logic [1:0] {
        SEL_EMPTY = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_class_e;

endpackage

// File: rtl/bus_onehot_enc.sv
// Combinational one-hot to binary encoder. The MSB maps to code 1; multi-hot
// inputs encode to SEL_NONE and raise o_multi, so the output is never X.
module bus_onehot_enc
    import bus_sel_pipe_pkg::*;
#(
    parameter int NUM_SLAVE = DEFAULT_NUM_SLAVE,
    parameter int SEL_W     = min_sel_w(DEFAULT_NUM_SLAVE)
) (
    input  logic [NUM_SLAVE-1:0] i_onehot,
    output logic [SEL_W-1:0]     o_enc,
    output logic                 o_any,
    output logic                 o_multi
);

    localparam int CNT_BITS = $clog2(NUM_SLAVE + 1);

    if (NUM_SLAVE < 1 || NUM_SLAVE > MAX_NUM_SLAVE) begin : g_bad_num_slave
        $error("bus_onehot_enc: NUM_SLAVE=%0d outside 1..%0d", NUM_SLAVE, MAX_NUM_SLAVE);
    end
    if (SEL_W < min_sel_w(NUM_SLAVE)) begin : g_bad_sel_w
        $error("bus_onehot_enc: SEL_W=%0d cannot encode %0d slaves", SEL_W, NUM_SLAVE);
    end

    logic [CNT_BITS-1:0] w_count;
    logic [SEL_W-1:0]    w_code;
    sel_class_e          w_class;

    always_comb begin
        w_count = '0;
        w_code  = '0;
        for (int unsigned i = 0; i < NUM_SLAVE; i++) begin
            if (i_onehot[i]) begin
                w_count = w_count + CNT_BITS'(1);
                w_code  = w_code | SEL_W'(NUM_SLAVE - i);
            end
        end
    end

    always_comb begin
        w_class = SEL_EMPTY;
        if (w_count > CNT_BITS'(1)) begin
            w_class = SEL_MULTI;
        end else if (w_count == CNT_BITS'(1)) begin
            w_class = SEL_ONE;
        end
    end

    assign o_any   = (w_class != SEL_EMPTY);
    assign o_multi = (w_class == SEL_MULTI);
    assign o_enc   = (w_class == SEL_ONE) ? w_code : SEL_W'(SEL_NONE);

endmodule

// File: rtl/bus_sel_pipe.sv
// Address-phase slave-select encoder with a wait-state-aware data-phase select
// register and illegal-encoding monitor (pulse, sticky flag, saturating count).
module bus_sel_pipe
    import bus_sel_pipe_pkg::*;
#(
    parameter int NUM_SLAVE = DEFAULT_NUM_SLAVE,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SLAVE-1:0] slave_sel,
    input  logic                 addr_valid,
    input  logic                 data_ready,
    input  logic                 err_clr,
    output logic [SEL_W-1:0]     select_sel,
    output logic [SEL_W-1:0]     data_sel,
    output logic                 sel_err,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt
);

    if (NUM_SLAVE < 1 || NUM_SLAVE > MAX_NUM_SLAVE) begin : g_bad_num_slave
        $error("bus_sel_pipe: NUM_SLAVE=%0d outside 1..%0d", NUM_SLAVE, MAX_NUM_SLAVE);
    end
    if (SEL_W < min_sel_w(NUM_SLAVE)) begin : g_bad_sel_w
        $error("bus_sel_pipe: SEL_W=%0d cannot encode %0d slaves", SEL_W, NUM_SLAVE);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("bus_sel_pipe: CNT_W=%0d must be at least 1", CNT_W);
    end

    logic [SEL_W-1:0] w_enc;
    logic             w_any;
    logic             w_multi;
    logic             w_accept;
    logic             w_err;

    logic [SEL_W-1:0] r_data_sel;
    logic             r_sel_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_cnt;

    bus_onehot_enc #(
        .NUM_SLAVE (NUM_SLAVE),
        .SEL_W     (SEL_W)
    ) u_enc (
        .i_onehot (slave_sel),
        .o_enc    (w_enc),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    assign w_accept = addr_valid & data_ready;
    assign w_err    = w_accept & w_multi;

    // A wait state (data_ready low) freezes the data-phase select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_sel <= '0;
        end else if (data_ready) begin
            r_data_sel <= (addr_valid && w_any) ? w_enc : SEL_W'(SEL_NONE);
        end
    end

    // A new error outranks a same-cycle clear for both flag and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_sel_err <= w_err;
            if (w_err) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
            if (err_clr) begin
                r_err_cnt <= w_err ? CNT_W'(1) : '0;
            end else if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign select_sel = w_enc;
    assign data_sel   = r_data_sel;
    assign sel_err    = r_sel_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_bus_sel_pipe.sv
// Bench for bus_sel_pipe: a 5-slave/2-bit-counter instance and a 12-slave
// instance, each checked against a behavioural model of the select rules.
module tb_bus_sel_pipe;

    logic clk;
    logic reset_n;

    logic [4:0]  a_sel;
    logic        a_av, a_dr, a_clr;
    logic [2:0]  a_select_sel, a_data_sel;
    logic        a_sel_err, a_sticky;
    logic [1:0]  a_cnt;

    logic [11:0] b_sel;
    logic        b_av, b_dr, b_clr;
    logic [3:0]  b_select_sel, b_data_sel;
    logic        b_sel_err, b_sticky;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    bus_sel_pipe #(.NUM_SLAVE(5), .SEL_W(3), .CNT_W(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .slave_sel(a_sel), .addr_valid(a_av),
        .data_ready(a_dr), .err_clr(a_clr), .select_sel(a_select_sel),
        .data_sel(a_data_sel), .sel_err(a_sel_err), .err_sticky(a_sticky),
        .err_cnt(a_cnt)
    );

    bus_sel_pipe #(.NUM_SLAVE(12), .SEL_W(4), .CNT_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .slave_sel(b_sel), .addr_valid(b_av),
        .data_ready(b_dr), .err_clr(b_clr), .select_sel(b_select_sel),
        .data_sel(b_data_sel), .sel_err(b_sel_err), .err_sticky(b_sticky),
        .err_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data_sel;
        int sel_err;
        int sticky;
        int cnt;
    } mstate_t;

    mstate_t ma, mb;

    // Slave k sits at bit n-1-k and encodes as k+1; anything not exactly one-hot is 0.
    function automatic int ref_enc(input logic [15:0] sel, input int n);
        if ($countones(sel) != 1) return 0;
        for (int k = 0; k < n; k++)
            if (sel[n-1-k]) return k + 1;
        return 0;
    endfunction

    function automatic mstate_t ref_next(input mstate_t s, input logic [15:0] sel, input int n,
                                         input int cw, input bit av, input bit dr, input bit clr);
        mstate_t r;
        bit err;
        int cmax;
        r    = s;
        cmax = (1 << cw) - 1;
        err  = av && dr && ($countones(sel) > 1);
        if (dr) r.data_sel = av ? ref_enc(sel, n) : 0;
        r.sel_err = err ? 1 : 0;
        if (err) r.sticky = 1;
        else if (clr) r.sticky = 0;
        if (clr) r.cnt = err ? 1 : 0;
        else if (err) r.cnt = (s.cnt + 1 > cmax) ? cmax : s.cnt + 1;
        return r;
    endfunction

    function automatic mstate_t ref_reset();
        mstate_t r;
        r.data_sel = 0; r.sel_err = 0; r.sticky = 0; r.cnt = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " a.data_sel"}, 32'(a_data_sel), ma.data_sel);
        chk({tag, " a.sel_err"},  32'(a_sel_err),  ma.sel_err);
        chk({tag, " a.sticky"},   32'(a_sticky),   ma.sticky);
        chk({tag, " a.cnt"},      32'(a_cnt),      ma.cnt);
        chk({tag, " b.data_sel"}, 32'(b_data_sel), mb.data_sel);
        chk({tag, " b.sel_err"},  32'(b_sel_err),  mb.sel_err);
        chk({tag, " b.sticky"},   32'(b_sticky),   mb.sticky);
        chk({tag, " b.cnt"},      32'(b_cnt),      mb.cnt);
    endtask

    // Inputs are already driven; check the combinational encode, clock once, check registers.
    task automatic tick(input string tag);
        #1;
        chk({tag, " a.select_sel"}, 32'(a_select_sel), ref_enc(16'(a_sel), 5));
        chk({tag, " b.select_sel"}, 32'(b_select_sel), ref_enc(16'(b_sel), 12));
        @(posedge clk);
        ma = ref_next(ma, 16'(a_sel), 5, 2, a_av, a_dr, a_clr);
        mb = ref_next(mb, 16'(b_sel), 12, 8, b_av, b_dr, b_clr);
        #1;
        chk_regs(tag);
    endtask

    task automatic drive_a(input logic [4:0] sel, input bit av, input bit dr, input bit clr);
        a_sel = sel; a_av = av; a_dr = dr; a_clr = clr;
    endtask

    task automatic drive_b(input logic [11:0] sel, input bit av, input bit dr, input bit clr);
        b_sel = sel; b_av = av; b_dr = dr; b_clr = clr;
    endtask

    function automatic logic [15:0] rand_sel(input int n);
        logic [15:0] mask;
        int pick;
        mask = 16'((1 << n) - 1);
        pick = int'($urandom_range(0, 3));
        if (pick == 0) return 16'h0;
        if (pick == 3) return 16'($urandom) & mask;
        return 16'(1) << $urandom_range(0, n - 1);
    endfunction

    initial begin
        logic [15:0] rs;
        drive_a(5'b0, 1'b0, 1'b0, 1'b0);
        drive_b(12'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        ma = ref_reset();
        mb = ref_reset();
        #2;
        chk_regs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Legacy map with back-to-back accepts.
        begin
            logic [4:0] legacy [6];
            legacy = '{5'b00000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
            for (int i = 0; i < 6; i++) begin
                drive_a(legacy[i], 1'b1, 1'b1, 1'b0);
                #1;
                chk("legacy select_sel const", 32'(a_select_sel), i);
                tick("legacy");
                chk("legacy data_sel const", 32'(a_data_sel), i);
            end
        end

        // Wait state holds the accepted select.
        drive_a(5'b01000, 1'b1, 1'b1, 1'b0);
        tick("wait accept");
        for (int i = 0; i < 3; i++) begin
            drive_a(5'b00001, 1'b1, 1'b0, 1'b0);
            tick("wait hold");
            chk("wait hold const", 32'(a_data_sel), 2);
        end
        drive_a(5'b00001, 1'b1, 1'b1, 1'b0);
        tick("wait release");
        chk("wait release const", 32'(a_data_sel), 5);

        // Multi-hot accepted, then the same pattern without addr_valid.
        drive_a(5'b11000, 1'b1, 1'b1, 1'b0);
        tick("multi accept");
        chk("multi sel_err const", 32'(a_sel_err), 1);
        chk("multi cnt const", 32'(a_cnt), 1);
        drive_a(5'b11000, 1'b0, 1'b1, 1'b0);
        tick("multi no valid");
        chk("multi pulse end const", 32'(a_sel_err), 0);
        drive_a(5'b11000, 1'b1, 1'b0, 1'b0);
        tick("multi in wait");

        // Saturation of the 2-bit counter and clear precedence.
        drive_a(5'b00000, 1'b0, 1'b1, 1'b1);
        tick("pre clear");
        for (int i = 0; i < 4; i++) begin
            drive_a(5'b10001, 1'b1, 1'b1, 1'b0);
            tick("saturate");
            chk("saturate cnt const", 32'(a_cnt), (i < 3) ? i + 1 : 3);
        end
        drive_a(5'b00110, 1'b1, 1'b1, 1'b1);
        tick("clear with error");
        chk("clear with error cnt const", 32'(a_cnt), 1);
        drive_a(5'b00000, 1'b1, 1'b1, 1'b1);
        tick("clear alone");
        chk("clear alone sticky const", 32'(a_sticky), 0);

        // Async reset asserted mid wait state.
        drive_a(5'b00000, 1'b0, 1'b1, 1'b1);
        tick("pre reset clear");
        for (int i = 0; i < 2; i++) begin
            drive_a(5'b01010, 1'b1, 1'b1, 1'b0);
            tick("pre reset err");
        end
        drive_a(5'b00100, 1'b1, 1'b1, 1'b0);
        tick("pre reset accept");
        drive_a(5'b00100, 1'b1, 1'b0, 1'b0);
        tick("pre reset wait");
        chk("pre reset data_sel const", 32'(a_data_sel), 3);
        chk("pre reset cnt const", 32'(a_cnt), 2);
        #2;
        reset_n = 1'b0;
        ma = ref_reset();
        mb = ref_reset();
        #1;
        chk_regs("async reset");
        #2;
        reset_n = 1'b1;
        drive_a(5'b00100, 1'b1, 1'b1, 1'b0);
        tick("post reset");
        chk("post reset data_sel const", 32'(a_data_sel), 3);

        // 12-slave instance: walking one, all-zero, bits 11 and 0 together.
        for (int i = 11; i >= 0; i--) begin
            logic [11:0] w;
            w = 12'(1) << i;
            drive_b(w, 1'b1, 1'b1, 1'b0);
            tick("walk12");
            chk("walk12 data_sel const", 32'(b_data_sel), 12 - i);
        end
        drive_b(12'h000, 1'b1, 1'b1, 1'b0);
        tick("zero12");
        drive_b(12'h801, 1'b1, 1'b1, 1'b0);
        tick("multi12");
        chk("multi12 sel_err const", 32'(b_sel_err), 1);

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            rs = rand_sel(5);
            drive_a(rs[4:0], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
            rs = rand_sel(12);
            drive_b(rs[11:0], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
